// File: rtl/pong_game_engine.sv
// Per-frame Pong game logic: paddles, ball, scores and serve/play/over sequencing.
// Buttons and start are synchronized here; all state advances only on frame_pulse.
module pong_game_engine #(
    parameter int PADDLE_H     = 80,
    parameter int PADDLE_STEP  = 4,
    parameter int BALL_STEP    = 2,
    parameter int SERVE_FRAMES = 60,
    parameter int WIN_SCORE    = 9
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_pulse,
    input  logic       p1_up,
    input  logic       p1_dn,
    input  logic       p2_up,
    input  logic       p2_dn,
    input  logic       start,
    output logic [9:0] y1,
    output logic [9:0] y2,
    output logic [9:0] xb,
    output logic [9:0] yb,
    output logic [3:0] score1,
    output logic [3:0] score2,
    output logic       game_over
);

    typedef enum logic [1:0] {SERVE, PLAY, OVER} state_t;

    localparam logic [9:0]         PADDLE_Y0  = 10'd200;
    localparam logic [9:0]         BALL_X0    = 10'd315;
    localparam logic [9:0]         BALL_Y0    = 10'd235;
    localparam logic signed [10:0] S_ZERO     = '0;
    localparam logic signed [10:0] PADDLE_MAX = 11'(480 - PADDLE_H);
    localparam logic signed [10:0] P_STEP     = 11'(PADDLE_STEP);
    localparam logic signed [10:0] B_STEP     = 11'(BALL_STEP);
    localparam logic signed [10:0] BALL_Y_MAX = 11'd470;
    localparam logic signed [10:0] BALL_X_MIN = 11'd10;
    localparam logic signed [10:0] BALL_X_MAX = 11'd620;
    localparam logic [10:0]        PAD_H11    = 11'(PADDLE_H);
    localparam logic [7:0]         SERVE_LAST = 8'(SERVE_FRAMES - 1);
    localparam logic [3:0]         WIN        = 4'(WIN_SCORE);

    state_t            state, state_n;
    logic [4:0]        sync_a, sync_b;
    logic              start_req;
    logic              b1_up, b1_dn, b2_up, b2_dn;
    logic              dx_right, dx_n, dy_down, dy_n;
    logic [7:0]        cnt, cnt_n;
    logic [9:0]        y1_n, y2_n, xb_n, yb_n;
    logic [3:0]        score1_n, score2_n, inc1, inc2;
    logic signed [10:0] nx, ny;

    assign b1_up     = sync_b[0];
    assign b1_dn     = sync_b[1];
    assign b2_up     = sync_b[2];
    assign b2_dn     = sync_b[3];
    assign game_over = (state == OVER);

    function automatic logic [9:0] move_paddle(input logic [9:0] y, input logic up, input logic dn);
        logic signed [10:0] t;
        t = $signed({1'b0, y});
        if (up && !dn)
            t = t - P_STEP;
        else if (dn && !up)
            t = t + P_STEP;
        if (t < S_ZERO)
            t = S_ZERO;
        else if (t > PADDLE_MAX)
            t = PADDLE_MAX;
        return 10'(t);
    endfunction

    function automatic logic [3:0] sat_inc(input logic [3:0] s);
        return (s == 4'hF) ? s : s + 4'd1;
    endfunction

    function automatic logic paddle_hit(input logic [9:0] ball_y, input logic [9:0] pad_y);
        return (({1'b0, ball_y} + 11'd10) > {1'b0, pad_y}) &&
               ({1'b0, ball_y} < ({1'b0, pad_y} + PAD_H11));
    endfunction

    // Start request stays pending until the next frame_pulse consumes it, in any state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_a    <= '0;
            sync_b    <= '0;
            start_req <= 1'b0;
        end else begin
            sync_a    <= {start, p2_dn, p2_up, p1_dn, p1_up};
            sync_b    <= sync_a;
            start_req <= frame_pulse ? 1'b0 : (start_req | sync_b[4]);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= SERVE;
            y1       <= PADDLE_Y0;
            y2       <= PADDLE_Y0;
            xb       <= BALL_X0;
            yb       <= BALL_Y0;
            score1   <= '0;
            score2   <= '0;
            dx_right <= 1'b1;
            dy_down  <= 1'b1;
            cnt      <= '0;
        end else begin
            state    <= state_n;
            y1       <= y1_n;
            y2       <= y2_n;
            xb       <= xb_n;
            yb       <= yb_n;
            score1   <= score1_n;
            score2   <= score2_n;
            dx_right <= dx_n;
            dy_down  <= dy_n;
            cnt      <= cnt_n;
        end
    end

    always_comb begin
        state_n  = state;
        y1_n     = y1;
        y2_n     = y2;
        xb_n     = xb;
        yb_n     = yb;
        score1_n = score1;
        score2_n = score2;
        dx_n     = dx_right;
        dy_n     = dy_down;
        cnt_n    = cnt;
        inc1     = sat_inc(score1);
        inc2     = sat_inc(score2);
        ny       = $signed({1'b0, yb}) + (dy_down ? B_STEP : -B_STEP);
        nx       = $signed({1'b0, xb}) + (dx_right ? B_STEP : -B_STEP);

        if (frame_pulse) begin
            case (state)
                SERVE: begin
                    y1_n = move_paddle(y1, b1_up, b1_dn);
                    y2_n = move_paddle(y2, b2_up, b2_dn);
                    xb_n = BALL_X0;
                    yb_n = BALL_Y0;
                    if (cnt == SERVE_LAST) begin
                        cnt_n   = '0;
                        state_n = PLAY;
                    end else begin
                        cnt_n = cnt + 8'd1;
                    end
                end
                PLAY: begin
                    y1_n = move_paddle(y1, b1_up, b1_dn);
                    y2_n = move_paddle(y2, b2_up, b2_dn);
                    if (ny <= S_ZERO) begin
                        yb_n = '0;
                        dy_n = 1'b1;
                    end else if (ny >= BALL_Y_MAX) begin
                        yb_n = 10'(BALL_Y_MAX);
                        dy_n = 1'b0;
                    end else begin
                        yb_n = 10'(ny);
                    end
                    xb_n = 10'(nx);
                    // Hit tests use y1/y2 from before this frame's paddle move; a miss overrides the vertical result
                    if (!dx_right && nx <= BALL_X_MIN) begin
                        if (paddle_hit(yb, y1)) begin
                            xb_n = 10'(BALL_X_MIN);
                            dx_n = 1'b1;
                        end else begin
                            score2_n = inc2;
                            dx_n     = 1'b0;
                            dy_n     = ~dy_down;
                            xb_n     = BALL_X0;
                            yb_n     = BALL_Y0;
                            state_n  = (inc2 == WIN) ? OVER : SERVE;
                        end
                    end else if (dx_right && nx >= BALL_X_MAX) begin
                        if (paddle_hit(yb, y2)) begin
                            xb_n = 10'(BALL_X_MAX);
                            dx_n = 1'b0;
                        end else begin
                            score1_n = inc1;
                            dx_n     = 1'b1;
                            dy_n     = ~dy_down;
                            xb_n     = BALL_X0;
                            yb_n     = BALL_Y0;
                            state_n  = (inc1 == WIN) ? OVER : SERVE;
                        end
                    end
                end
                OVER: begin
                    if (start_req) begin
                        score1_n = '0;
                        score2_n = '0;
                        y1_n     = PADDLE_Y0;
                        y2_n     = PADDLE_Y0;
                        state_n  = SERVE;
                    end
                end
                default: state_n = SERVE;
            endcase
        end
    end

endmodule

// File: tb/tb_pong_game_engine.sv
// Randomized and directed bench for pong_game_engine against a frame-level game model.
module tb_pong_game_engine;

    logic       clk = 1'b0;
    logic       rst, frame_pulse, p1_up, p1_dn, p2_up, p2_dn, start;
    logic [9:0] y1, y2, xb, yb;
    logic [3:0] score1, score2;
    logic       game_over;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference game model: plain integers, one call per frame
    int m_y1, m_y2, m_xb, m_yb, m_s1, m_s2, m_cnt, m_phase;  // phase 0 serve, 1 play, 2 over
    bit m_right, m_down, m_req;

    always #5 clk = ~clk;

    pong_game_engine #(
        .PADDLE_H    (80),
        .PADDLE_STEP (4),
        .BALL_STEP   (2),
        .SERVE_FRAMES(60),
        .WIN_SCORE   (9)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .frame_pulse(frame_pulse),
        .p1_up      (p1_up),
        .p1_dn      (p1_dn),
        .p2_up      (p2_up),
        .p2_dn      (p2_dn),
        .start      (start),
        .y1         (y1),
        .y2         (y2),
        .xb         (xb),
        .yb         (yb),
        .score1     (score1),
        .score2     (score2),
        .game_over  (game_over)
    );

    function automatic void model_reset();
        m_y1 = 200; m_y2 = 200; m_xb = 315; m_yb = 235;
        m_s1 = 0; m_s2 = 0; m_cnt = 0; m_phase = 0;
        m_right = 1; m_down = 1; m_req = 0;
    endfunction

    function automatic int clamp(int v, int lo, int hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

    function automatic void model_frame(bit u1, bit d1, bit u2, bit d2);
        int oy1, oy2, nx, ny;
        bit ndown, scored, win, st;
        st = m_req;
        m_req = 0;
        if (m_phase == 2) begin
            if (st) begin
                m_s1 = 0; m_s2 = 0; m_y1 = 200; m_y2 = 200; m_phase = 0;
            end
            return;
        end
        oy1 = m_y1;
        oy2 = m_y2;
        if (u1 != d1) m_y1 = clamp(m_y1 + (u1 ? -4 : 4), 0, 400);
        if (u2 != d2) m_y2 = clamp(m_y2 + (u2 ? -4 : 4), 0, 400);
        if (m_phase == 0) begin
            m_cnt++;
            if (m_cnt == 60) begin
                m_cnt = 0;
                m_phase = 1;
            end
            return;
        end
        ny = m_yb + (m_down ? 2 : -2);
        ndown = m_down;
        if (ny <= 0) begin ny = 0; ndown = 1; end
        else if (ny >= 470) begin ny = 470; ndown = 0; end
        scored = 0;
        win = 0;
        if (!m_right) begin
            nx = m_xb - 2;
            if (nx <= 10) begin
                if (m_yb + 10 > oy1 && m_yb < oy1 + 80) begin
                    nx = 10; m_right = 1;
                end else begin
                    scored = 1; m_s2 = (m_s2 < 15) ? m_s2 + 1 : 15; m_right = 0; win = (m_s2 == 9);
                end
            end
        end else begin
            nx = m_xb + 2;
            if (nx >= 620) begin
                if (m_yb + 10 > oy2 && m_yb < oy2 + 80) begin
                    nx = 620; m_right = 0;
                end else begin
                    scored = 1; m_s1 = (m_s1 < 15) ? m_s1 + 1 : 15; m_right = 1; win = (m_s1 == 9);
                end
            end
        end
        if (scored) begin
            m_xb = 315; m_yb = 235; m_down = !m_down; m_phase = win ? 2 : 0;
        end else begin
            m_xb = nx; m_yb = ny; m_down = ndown;
        end
    endfunction

    function automatic logic [48:0] model_vec();
        return {10'(m_y1), 10'(m_y2), 10'(m_xb), 10'(m_yb), 4'(m_s1), 4'(m_s2), (m_phase == 2)};
    endfunction

    function automatic logic [48:0] dut_vec();
        return {y1, y2, xb, yb, score1, score2, game_over};
    endfunction

    task automatic do_frame(bit u1, bit d1, bit u2, bit d2, bit st);
        @(negedge clk);
        p1_up = u1; p1_dn = d1; p2_up = u2; p2_dn = d2; start = st;
        if (st) m_req = 1;
        repeat (2) @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        frame_pulse = 1'b1;
        @(negedge clk);
        frame_pulse = 1'b0;
        model_frame(u1, d1, u2, d2);
    endtask

    task automatic apply_reset();
        rst = 1'b0; frame_pulse = 1'b0; start = 1'b0;
        p1_up = 1'b0; p1_dn = 1'b0; p2_up = 1'b0; p2_dn = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        logic [48:0] exp_v;
        exp_v = {10'd200, 10'd200, 10'd315, 10'd235, 4'd0, 4'd0, 1'b0};
        rst = 1'b0; frame_pulse = 1'b0; start = 1'b0;
        p1_up = 1'b1; p1_dn = 1'b0; p2_up = 1'b0; p2_dn = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (dut_vec() !== exp_v) begin
            n_bad++;
            $display("FAIL reset_held: got %h expected %h", dut_vec(), exp_v);
        end
        apply_reset();
        n_cmp++;
        if (dut_vec() !== model_vec()) begin
            n_bad++;
            $display("FAIL reset_release: got %h expected %h", dut_vec(), model_vec());
        end
    endtask

    task automatic test_serve();
        apply_reset();
        for (int k = 1; k <= 60; k++) begin
            do_frame(0, 0, 0, 0, 0);
            n_cmp++;
            if (xb !== 10'd315 || yb !== 10'd235 || dut_vec() !== model_vec()) begin
                n_bad++;
                $display("FAIL serve_hold frame %0d: got %h expected %h", k, dut_vec(), model_vec());
            end
        end
        do_frame(0, 0, 0, 0, 0);
        n_cmp++;
        if (xb !== 10'd317 || yb !== 10'd237 || dut_vec() !== model_vec()) begin
            n_bad++;
            $display("FAIL serve_launch: got xb=%0d yb=%0d expected xb=317 yb=237", xb, yb);
        end
    endtask

    task automatic test_paddles();
        int e;
        apply_reset();
        for (int k = 1; k <= 5; k++) begin
            do_frame(1, 1, 0, 0, 0);
            n_cmp++;
            if (y1 !== 10'd200 || dut_vec() !== model_vec()) begin
                n_bad++;
                $display("FAIL paddle_both frame %0d: got y1=%0d expected 200", k, y1);
            end
        end
        for (int k = 1; k <= 60; k++) begin
            do_frame(1, 0, 0, 0, 0);
            e = clamp(200 - 4 * k, 0, 400);
            n_cmp++;
            if (y1 !== 10'(e) || dut_vec() !== model_vec()) begin
                n_bad++;
                $display("FAIL paddle_up frame %0d: got y1=%0d expected %0d", k, y1, e);
            end
        end
        for (int k = 1; k <= 60; k++) begin
            do_frame(0, 0, 0, 1, 0);
            e = clamp(200 + 4 * k, 0, 400);
            n_cmp++;
            if (y2 !== 10'(e) || dut_vec() !== model_vec()) begin
                n_bad++;
                $display("FAIL paddle_dn frame %0d: got y2=%0d expected %0d", k, y2, e);
            end
        end
    endtask

    // P1 keeps its paddle away from the ball while P2 tracks it, so P2 wins 9-0
    task automatic test_game_over();
        bit u1, d1, u2, d2, bad;
        int tgt;
        logic [48:0] frozen;
        apply_reset();
        bad = 0;
        for (int f = 0; f < 4000 && m_phase != 2 && !bad; f++) begin
            u1 = (m_yb >= 240);
            d1 = !u1;
            tgt = m_yb - 35;
            u2 = (m_y2 > tgt + 2);
            d2 = (m_y2 < tgt - 2);
            do_frame(u1, d1, u2, d2, 0);
            n_cmp++;
            if (dut_vec() !== model_vec()) begin
                n_bad++;
                bad = 1;
                $display("FAIL rally frame %0d: got %h expected %h", f, dut_vec(), model_vec());
            end
        end
        n_cmp++;
        if (m_phase != 2 || game_over !== 1'b1 || score2 !== 4'd9 || score1 !== 4'd0 ||
            xb !== 10'd315 || yb !== 10'd235) begin
            n_bad++;
            $display("FAIL game_over_reached: got go=%0b s1=%0d s2=%0d xb=%0d yb=%0d expected go=1 s1=0 s2=9 xb=315 yb=235",
                     game_over, score1, score2, xb, yb);
        end
        frozen = model_vec();
        for (int k = 0; k < 10; k++) begin
            logic [3:0] b;
            b = 4'($urandom);
            do_frame(b[0], b[1], b[2], b[3], 0);
            n_cmp++;
            if (dut_vec() !== frozen) begin
                n_bad++;
                $display("FAIL over_frozen frame %0d: got %h expected %h", k, dut_vec(), frozen);
            end
        end
        do_frame(1, 0, 0, 1, 1);
        n_cmp++;
        if (score1 !== 4'd0 || score2 !== 4'd0 || y1 !== 10'd200 || y2 !== 10'd200 ||
            game_over !== 1'b0 || dut_vec() !== model_vec()) begin
            n_bad++;
            $display("FAIL restart: got %h expected %h", dut_vec(), model_vec());
        end
    endtask

    task automatic test_random();
        logic [3:0] b;
        bit st;
        apply_reset();
        for (int f = 0; f < 1500; f++) begin
            b = 4'($urandom);
            st = ($urandom_range(0, 19) == 0);
            do_frame(b[0], b[1], b[2], b[3], st);
            n_cmp++;
            if (dut_vec() !== model_vec()) begin
                n_bad++;
                $display("FAIL random frame %0d: got %h expected %h", f, dut_vec(), model_vec());
                break;
            end
        end
    endtask

    task automatic test_async_reset();
        logic [48:0] exp_v;
        exp_v = {10'd200, 10'd200, 10'd315, 10'd235, 4'd0, 4'd0, 1'b0};
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        n_cmp++;
        if (dut_vec() !== exp_v) begin
            n_bad++;
            $display("FAIL async_reset: got %h expected %h", dut_vec(), exp_v);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        model_reset();
        do_frame(0, 1, 1, 0, 0);
        n_cmp++;
        if (dut_vec() !== model_vec()) begin
            n_bad++;
            $display("FAIL after_async_reset: got %h expected %h", dut_vec(), model_vec());
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_serve();
        test_paddles();
        test_game_over();
        test_random();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
